imem_dmem_responder: RTL and testbench
======================================

Name: imem_dmem_responder

Overview:
- Memory-side responder for the single-cycle processor's instruction-fetch and data-access interface.
- Serves instruction fetches and lw/sw data accesses from one word-organised, single-ported array.
- Each request completes after a fixed, programmable latency and uses a four-phase req/ack handshake.
- Includes a preload port so benches can load program images before execution.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the array
ADDR_W, 10, word-index width; must equal log2(DEPTH_WORDS)
BASE_ADDR, 32'h0000_3000, byte address mapped to word index 0 (the processor's reset PC)
LATENCY, 2, edges from request acceptance to ack; legal range is 1..15

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
inst_req  in  1  instruction fetch request (level, four-phase)
inst_addr  in  32  fetch byte address; held stable while inst_req=1
inst_data  out  32  fetched instruction; valid while inst_ack=1
inst_ack  out  1  fetch complete
data_req  in  1  data access request (level, four-phase)
mem_read  in  1  data read (lw); held with data_req
mem_write  in  1  data write (sw); held with data_req
data_addr  in  32  data byte address; held with data_req
data_wdata  in  32  write data; held with data_req
data_rdata  out  32  read data; valid while data_ack=1
data_ack  out  1  data access complete
err  out  1  current ack carries an error; valid with either ack
busy  out  1  high in every state except IDLE
load_en  in  1  preload write strobe
load_idx  in  ADDR_W  preload word index (direct, not byte address)
load_data  in  32  preload word

Behaviour:
- Reset (async): state=IDLE; all outputs=0; latency counter=0. Array contents are not cleared.
- Reset mid-operation aborts the access. A pending write is not committed.
- States: IDLE, BUSY_I, BUSY_D, ACK_I, ACK_D.
- IDLE, edge with load_en=1:
  - Write load_data to array[load_idx].
  - Do not accept any request on that edge; requests wait.
- load_en outside IDLE is ignored.
- IDLE, edge with load_en=0:
  - data_req=1 -> capture address, controls and wdata; go to BUSY_D. Data has priority.
  - Else inst_req=1 -> capture inst_addr; go to BUSY_I.
  - A request losing arbitration stays pending and is accepted after the winner's handshake ends.
- BUSY_x: counter loads LATENCY-1 on acceptance and decrements each edge.
  - On the edge where the counter is 0, go to ACK_x.
  - On that same edge, register the response: inst_data/data_rdata = array word; a write commits to the array.
  - ack therefore rises exactly LATENCY edges after the accepting edge.
- ACK_x: hold ack=1 and the response data until req is sampled low.
  - On that edge: ack=0, data outputs=0, err=0, next state IDLE.
  - Requests are not re-accepted until the next IDLE edge, so a req held high is never served twice.
- Address decode:
  - Word index = (addr - BASE_ADDR) >> 2, computed in 32-bit unsigned arithmetic; subtraction wraps.
  - Error conditions: addr[1:0] != 0, index >= DEPTH_WORDS (this includes addr < BASE_ADDR via wrap), or mem_read=mem_write=1.
  - mem_read=mem_write=0 on data_req is also an error.
- Error handling: access still takes LATENCY edges; err=1 with ack; read data returned is 0; no array write.
- Read-after-write: a read accepted after a write's ack phase returns the new value.
- Input changes while in BUSY/ACK are ignored; the captured request values are used.
- busy=1 in BUSY_I, BUSY_D, ACK_I, ACK_D.

Test Plan:
1. Preload array[0]=32'h2008_0005. Raise inst_req with inst_addr=32'h3000 (LATENCY=2). Required: inst_ack rises on 2nd edge after acceptance with inst_data=32'h2008_0005. Drop req; ack falls on next edge, busy=0.
2. Data write with data_addr=32'h3010, wdata=32'hDEAD_BEEF, then data read of 32'h3010. Required: data_rdata=32'hDEAD_BEEF, err=0.
3. inst_req and data_req raised on the same edge. Required: data_ack first; inst_ack follows LATENCY edges after the data handshake returns to IDLE; both responses correct.
4. Error cases:
   - read of 32'h3002 -> err=1, data_rdata=0.
   - read of 32'h2FFC -> err=1, data_rdata=0.
   - write to 32'h3000+4*DEPTH_WORDS -> err=1, and array[0] and all other words are unchanged.
5. Write to 32'h3020 in flight; assert reset one edge before ack would rise. Required: outputs go 0 immediately; after reset, a read of 32'h3020 returns the pre-write value.
6. Hold inst_req high for 10 cycles after inst_ack. Required: exactly one fetch occurs, and ack stays high until req drops. Then pulse load_en during BUSY_I. Required: the load is ignored.

Source files
------------

// File: rtl/imem_dmem_responder_if.sv
// imem_dmem_responder_if: fetch, data-access and preload signals between processor side and memory responder
interface imem_dmem_responder_if #(parameter int ADDR_W = 10);
  logic inst_req, inst_ack, data_req, mem_read, mem_write, data_ack, err, busy, load_en;
  logic [31:0] inst_addr, inst_data, data_addr, data_wdata, data_rdata, load_data;
  logic [ADDR_W-1:0] load_idx;
  modport master (
    output inst_req, inst_addr, data_req, mem_read, mem_write, data_addr, data_wdata, load_en, load_idx, load_data,
    input inst_data, inst_ack, data_rdata, data_ack, err, busy
  );
  modport slave (
    input inst_req, inst_addr, data_req, mem_read, mem_write, data_addr, data_wdata, load_en, load_idx, load_data,
    output inst_data, inst_ack, data_rdata, data_ack, err, busy
  );
endinterface

// File: rtl/imem_dmem_responder.sv
// imem_dmem_responder: fixed-latency four-phase responder for instruction fetches and lw/sw over one word array
module imem_dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic reset,
  imem_dmem_responder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, ACK_I, ACK_D} state_t;
  state_t state, nxt;
  logic [3:0] cnt;
  logic [31:0] cap_addr, cap_wdata, off;
  logic cap_rd, cap_wr, bad, done, commit, accept, release_ack;
  logic [ADDR_W-1:0] idx;
  logic [31:0] mem [DEPTH_WORDS];
  always_comb begin
    off = cap_addr - BASE_ADDR;
    idx = off[ADDR_W+1:2];
    bad = (cap_addr[1:0] != 2'b00) || ((off >> 2) >= 32'(DEPTH_WORDS)) || (state == BUSY_D && cap_rd == cap_wr);
    done = (state == BUSY_I || state == BUSY_D) && cnt == 4'd0;
    commit = done && state == BUSY_D && cap_wr && !bad;
    nxt = state == IDLE   ? (bus.load_en ? IDLE : bus.data_req ? BUSY_D : bus.inst_req ? BUSY_I : IDLE)
        : state == BUSY_I ? (done ? ACK_I : BUSY_I)
        : state == BUSY_D ? (done ? ACK_D : BUSY_D)
        : state == ACK_I  ? (bus.inst_req ? ACK_I : IDLE)
        : state == ACK_D  ? (bus.data_req ? ACK_D : IDLE)
        : IDLE;
    accept = state == IDLE && nxt != IDLE;
    release_ack = (state == ACK_I || state == ACK_D) && nxt == IDLE;
  end
  assign bus.busy = state != IDLE;
  // The array has no reset; state is forced to IDLE by reset so an aborted write never reaches here.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.load_en) mem[bus.load_idx] <= bus.load_data;
    else if (commit) mem[idx] <= cap_wdata;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      cap_addr <= '0;
      cap_wdata <= '0;
      cap_rd <= 1'b0;
      cap_wr <= 1'b0;
      bus.inst_ack <= 1'b0;
      bus.data_ack <= 1'b0;
      bus.err <= 1'b0;
      bus.inst_data <= '0;
      bus.data_rdata <= '0;
    end else begin
      state <= nxt;
      cnt <= accept ? 4'(LATENCY - 1) : cnt != 4'd0 ? cnt - 4'd1 : cnt;
      if (accept) begin
        cap_addr <= nxt == BUSY_D ? bus.data_addr : bus.inst_addr;
        cap_rd <= bus.mem_read;
        cap_wr <= bus.mem_write;
        cap_wdata <= bus.data_wdata;
      end
      if (done) begin
        bus.inst_ack <= state == BUSY_I;
        bus.data_ack <= state == BUSY_D;
        bus.err <= bad;
        bus.inst_data <= (state == BUSY_I && !bad) ? mem[idx] : '0;
        bus.data_rdata <= (state == BUSY_D && !bad && cap_rd) ? mem[idx] : '0;
      end
      if (release_ack) begin
        bus.inst_ack <= 1'b0;
        bus.data_ack <= 1'b0;
        bus.err <= 1'b0;
        bus.inst_data <= '0;
        bus.data_rdata <= '0;
      end
    end
  end
endmodule

// File: tb/tb_imem_dmem_responder.sv
// tb_imem_dmem_responder: directed plus randomized checks of the responder against a word-array reference model
module tb_imem_dmem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT = 2;
  localparam logic [31:0] BASE = 32'h0000_3000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] model [DEPTH];
  always #5 clk = ~clk;
  imem_dmem_responder_if #(.ADDR_W(10)) bus();
  imem_dmem_responder #(.DEPTH_WORDS(DEPTH), .ADDR_W(10), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // reference: data access outcome from the address-map rules, updating the model on a good write
  task automatic model_data(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] wd,
                            output logic [31:0] er, output logic ee);
    logic [31:0] off;
    off = a - BASE;
    ee = a[1:0] != 2'b00 || off >= 32'(4 * DEPTH) || rd == wr;
    er = (!ee && rd) ? model[off / 4] : 32'h0;
    if (!ee && wr) model[off / 4] = wd;
  endtask

  task automatic model_inst(input logic [31:0] a, output logic [31:0] er, output logic ee);
    logic [31:0] off;
    off = a - BASE;
    ee = a[1:0] != 2'b00 || off >= 32'(4 * DEPTH);
    er = ee ? 32'h0 : model[off / 4];
  endtask

  task automatic load_word(input int i, input logic [31:0] d);
    bus.load_en = 1'b1;
    bus.load_idx = 10'(i);
    bus.load_data = d;
    @(negedge clk);
    bus.load_en = 1'b0;
    model[i] = d;
  endtask

  task automatic data_access(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] wd,
                             output logic [31:0] rdv, output logic e, output int lat,
                             output logic ack_after, output logic busy_after);
    bus.data_addr = a;
    bus.mem_read = rd;
    bus.mem_write = wr;
    bus.data_wdata = wd;
    bus.data_req = 1'b1;
    lat = 0;
    while (bus.data_ack !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    rdv = bus.data_rdata;
    e = bus.err;
    bus.data_req = 1'b0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    @(negedge clk);
    ack_after = bus.data_ack;
    busy_after = bus.busy;
  endtask

  task automatic inst_fetch(input logic [31:0] a, output logic [31:0] d, output logic e, output int lat,
                            output logic ack_after, output logic busy_after);
    bus.inst_addr = a;
    bus.inst_req = 1'b1;
    lat = 0;
    while (bus.inst_ack !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    d = bus.inst_data;
    e = bus.err;
    bus.inst_req = 1'b0;
    @(negedge clk);
    ack_after = bus.inst_ack;
    busy_after = bus.busy;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.inst_ack, bus.data_ack, bus.err, bus.inst_data, bus.data_rdata} !== 68'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b iack=%b dack=%b err=%b idata=%h drdata=%h expected all zero",
               bus.busy, bus.inst_ack, bus.data_ack, bus.err, bus.inst_data, bus.data_rdata);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.busy, bus.inst_ack, bus.data_ack, bus.err} !== 4'h0) begin
      n_fail++;
      $display("FAIL idle_after_reset: got busy=%b iack=%b dack=%b err=%b expected 0",
               bus.busy, bus.inst_ack, bus.data_ack, bus.err);
    end
  endtask

  task automatic test_fetch();
    logic [31:0] d;
    logic e, aa, ba;
    int lat;
    load_word(0, 32'h2008_0005);
    inst_fetch(32'h3000, d, e, lat, aa, ba);
    n_checks++;
    if (d !== 32'h2008_0005 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_data: got %h err=%b expected 20080005 err=0", d, e);
    end
    n_checks++;
    if (lat != LAT + 1) begin
      n_fail++;
      $display("FAIL fetch_latency: got %0d expected %0d", lat, LAT + 1);
    end
    n_checks++;
    if (aa !== 1'b0 || ba !== 1'b0 || bus.inst_data !== 32'h0) begin
      n_fail++;
      $display("FAIL fetch_release: got ack=%b busy=%b data=%h expected 0 0 0", aa, ba, bus.inst_data);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] d, er;
    logic e, ee, aa, ba;
    int lat;
    model_data(32'h3010, 1'b0, 1'b1, 32'hDEAD_BEEF, er, ee);
    data_access(32'h3010, 1'b0, 1'b1, 32'hDEAD_BEEF, d, e, lat, aa, ba);
    n_checks++;
    if (e !== 1'b0 || lat != LAT + 1 || aa !== 1'b0 || ba !== 1'b0) begin
      n_fail++;
      $display("FAIL write_handshake: got err=%b lat=%0d ack_after=%b busy_after=%b expected 0 %0d 0 0",
               e, lat, aa, ba, LAT + 1);
    end
    model_data(32'h3010, 1'b1, 1'b0, 32'h0, er, ee);
    data_access(32'h3010, 1'b1, 1'b0, 32'h0, d, e, lat, aa, ba);
    n_checks++;
    if (d !== 32'hDEAD_BEEF || e !== 1'b0 || lat != LAT + 1) begin
      n_fail++;
      $display("FAIL read_after_write: got %h err=%b lat=%0d expected deadbeef err=0 lat=%0d", d, e, lat, LAT + 1);
    end
  endtask

  task automatic test_arbitration();
    logic [31:0] er_d, er_i;
    logic ee;
    logic saw_i = 1'b0;
    int n = 0;
    model_data(32'h3040, 1'b1, 1'b0, 32'h0, er_d, ee);
    model_inst(32'h3008, er_i, ee);
    bus.data_addr = 32'h3040;
    bus.mem_read = 1'b1;
    bus.mem_write = 1'b0;
    bus.inst_addr = 32'h3008;
    bus.data_req = 1'b1;
    bus.inst_req = 1'b1;
    while (bus.data_ack !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
      if (bus.inst_ack === 1'b1) saw_i = 1'b1;
    end
    n_checks++;
    if (n != LAT + 1 || saw_i || bus.data_rdata !== er_d || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL arb_data_first: got lat=%0d inst_ack_seen=%b rdata=%h err=%b expected %0d 0 %h 0",
               n, saw_i, bus.data_rdata, bus.err, LAT + 1, er_d);
    end
    bus.data_req = 1'b0;
    bus.mem_read = 1'b0;
    n = 0;
    while (bus.inst_ack !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n != LAT + 2 || bus.inst_data !== er_i || bus.data_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL arb_inst_second: got wait=%0d data=%h dack=%b expected %0d %h 0",
               n, bus.inst_data, bus.data_ack, LAT + 2, er_i);
    end
    bus.inst_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.inst_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL arb_release: got busy=%b ack=%b expected 0 0", bus.busy, bus.inst_ack);
    end
  endtask

  task automatic test_errors();
    logic [31:0] d, er;
    logic e, ee, aa, ba;
    int lat;
    int bad_words = 0;
    logic [31:0] addrs [4] = '{32'h3002, 32'h2FFC, 32'h3004, 32'h3008};
    logic [1:0] ops [4] = '{2'b10, 2'b10, 2'b11, 2'b00};
    for (int i = 0; i < 4; i++) begin
      model_data(addrs[i], ops[i][1], ops[i][0], 32'h0, er, ee);
      data_access(addrs[i], ops[i][1], ops[i][0], 32'h0, d, e, lat, aa, ba);
      n_checks++;
      if (e !== 1'b1 || d !== 32'h0 || lat != LAT + 1) begin
        n_fail++;
        $display("FAIL err_read_%0d: got err=%b rdata=%h lat=%0d expected 1 0 %0d", i, e, d, lat, LAT + 1);
      end
    end
    model_data(BASE + 32'(4 * DEPTH), 1'b0, 1'b1, ~model[0], er, ee);
    data_access(BASE + 32'(4 * DEPTH), 1'b0, 1'b1, ~model[0], d, e, lat, aa, ba);
    n_checks++;
    if (e !== 1'b1 || lat != LAT + 1) begin
      n_fail++;
      $display("FAIL err_write_oob: got err=%b lat=%0d expected 1 %0d", e, lat, LAT + 1);
    end
    model_data(32'h3006, 1'b0, 1'b1, 32'h1234_5678, er, ee);
    data_access(32'h3006, 1'b0, 1'b1, 32'h1234_5678, d, e, lat, aa, ba);
    for (int i = 0; i < DEPTH; i++) begin
      model_data(BASE + 32'(4 * i), 1'b1, 1'b0, 32'h0, er, ee);
      data_access(BASE + 32'(4 * i), 1'b1, 1'b0, 32'h0, d, e, lat, aa, ba);
      if (d !== er || e !== 1'b0) begin
        bad_words++;
        if (bad_words <= 4) $display("FAIL sweep_word_%0d: got %h expected %h", i, d, er);
      end
    end
    n_checks++;
    if (bad_words != 0) begin
      n_fail++;
      $display("FAIL array_unchanged: got %0d corrupted words expected 0", bad_words);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] d, er, old;
    logic e, ee, aa, ba;
    int lat;
    old = model[8];
    bus.data_addr = 32'h3020;
    bus.mem_write = 1'b1;
    bus.mem_read = 1'b0;
    bus.data_wdata = ~old;
    bus.data_req = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b1 || bus.data_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_inflight: got busy=%b ack=%b expected 1 0", bus.busy, bus.data_ack);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.data_ack !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_outputs: got busy=%b ack=%b err=%b expected 0 0 0", bus.busy, bus.data_ack, bus.err);
    end
    bus.data_req = 1'b0;
    bus.mem_write = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    model_data(32'h3020, 1'b1, 1'b0, 32'h0, er, ee);
    data_access(32'h3020, 1'b1, 1'b0, 32'h0, d, e, lat, aa, ba);
    n_checks++;
    if (d !== old || er !== old || e !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_commit: got %h err=%b expected %h err=0", d, e, old);
    end
    bus.inst_addr = 32'h3000;
    bus.inst_req = 1'b1;
    repeat (LAT + 1) @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.inst_ack !== 1'b0 || bus.inst_data !== 32'h0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_ack_phase: got ack=%b data=%h busy=%b expected 0 0 0", bus.inst_ack, bus.inst_data, bus.busy);
    end
    bus.inst_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_hold_and_load();
    logic [31:0] d, er, old;
    logic e, ee, aa, ba;
    int n = 0;
    int drops = 0;
    model_inst(32'h3014, er, ee);
    bus.inst_addr = 32'h3014;
    bus.inst_req = 1'b1;
    while (bus.inst_ack !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.inst_ack !== 1'b1 || bus.busy !== 1'b1 || bus.inst_data !== er) drops++;
    end
    n_checks++;
    if (n != LAT + 1 || drops != 0) begin
      n_fail++;
      $display("FAIL hold_single_fetch: got lat=%0d drops=%0d expected %0d 0", n, drops, LAT + 1);
    end
    bus.inst_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.inst_ack !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_release: got ack=%b busy=%b expected 0 0", bus.inst_ack, bus.busy);
    end
    old = model[7];
    bus.inst_addr = 32'h301C;
    bus.inst_req = 1'b1;
    @(negedge clk);
    bus.load_en = 1'b1;
    bus.load_idx = 10'd7;
    bus.load_data = ~old;
    @(negedge clk);
    bus.load_en = 1'b0;
    n = 0;
    while (bus.inst_ack !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    bus.inst_req = 1'b0;
    n_checks++;
    if (bus.inst_data !== old) begin
      n_fail++;
      $display("FAIL busy_load_data: got %h expected %h", bus.inst_data, old);
    end
    @(negedge clk);
    inst_fetch(32'h301C, d, e, n, aa, ba);
    n_checks++;
    if (d !== old) begin
      n_fail++;
      $display("FAIL busy_load_ignored: got %h expected %h", d, old);
    end
  endtask

  task automatic test_load_priority();
    logic [31:0] nv;
    int n = 0;
    nv = $urandom;
    bus.load_en = 1'b1;
    bus.load_idx = 10'd33;
    bus.load_data = nv;
    bus.inst_addr = BASE + 32'd132;
    bus.inst_req = 1'b1;
    @(negedge clk);
    bus.load_en = 1'b0;
    model[33] = nv;
    n = 1;
    while (bus.inst_ack !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    bus.inst_req = 1'b0;
    n_checks++;
    if (n != LAT + 2 || bus.inst_data !== nv) begin
      n_fail++;
      $display("FAIL load_delays_request: got wait=%0d data=%h expected %0d %h", n, bus.inst_data, LAT + 2, nv);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] a, wd, d, er;
    logic e, ee, aa, ba, rd, wr;
    int lat, r;
    int bad_data = 0;
    int bad_lat = 0;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 7);
      a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
      a = r == 0 ? $urandom : r == 1 ? a + 32'($urandom_range(1, 3)) : a;
      wd = $urandom;
      if ($urandom_range(0, 2) == 0) begin
        model_inst(a, er, ee);
        inst_fetch(a, d, e, lat, aa, ba);
      end else begin
        r = $urandom_range(0, 9);
        rd = r < 5 || r == 9;
        wr = (r >= 5 && r < 9) || r == 9;
        model_data(a, rd, wr, wd, er, ee);
        data_access(a, rd, wr, wd, d, e, lat, aa, ba);
      end
      if (d !== er || e !== ee || aa !== 1'b0 || ba !== 1'b0) begin
        bad_data++;
        if (bad_data <= 4) $display("FAIL random_%0d: addr=%h got %h err=%b expected %h err=%b", i, a, d, e, er, ee);
      end
      if (lat != LAT + 1) bad_lat++;
    end
    n_checks++;
    if (bad_data != 0) begin
      n_fail++;
      $display("FAIL random_responses: got %0d wrong expected 0", bad_data);
    end
    n_checks++;
    if (bad_lat != 0) begin
      n_fail++;
      $display("FAIL random_latency: got %0d wrong expected 0", bad_lat);
    end
  endtask

  initial begin
    bus.inst_req = 1'b0;
    bus.inst_addr = '0;
    bus.data_req = 1'b0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.data_addr = '0;
    bus.data_wdata = '0;
    bus.load_en = 1'b0;
    bus.load_idx = '0;
    bus.load_data = '0;
    test_reset();
    for (int i = 0; i < DEPTH; i++) load_word(i, $urandom);
    test_fetch();
    test_write_read();
    test_arbitration();
    test_errors();
    test_reset_abort();
    test_hold_and_load();
    test_load_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
